mem_loader: RTL and testbench
=============================

MEM_LOADER -- requirements
Module: mem_loader

Interface
- REQ-001: Parameter CLKS_PER_BIT, default 16, CLK cycles per serial bit; legal range 4..65535.
- REQ-002: Parameter SYNC_BYTE, default 8'hA5, frame-start marker.
- REQ-003: CLK  in  1  system clock, rising edge.
- REQ-004: RESET  in  1  asynchronous, active-high reset.
- REQ-005: RXD  in  1  serial input, 8N1, LSB first, idle high.
- REQ-006: WRITE_MEM  out  1  write strobe to data memory, one cycle per byte.
- REQ-007: ADDRESS  out  8  data memory write address.
- REQ-008: DATA_IN  out  8  data memory write data.
- REQ-009: BUSY  out  1  high from accepted sync byte until frame end or abort.
- REQ-010: DONE  out  1  one-cycle pulse when a frame completes.
- REQ-011: ERROR  out  1  sticky framing-error flag.

Function
- REQ-012: RXD shall pass through a 2-flop synchronizer before any use; all timing below counts from the synchronized signal.
- REQ-013: Receiver states: R_IDLE, R_START, R_DATA, R_STOP.
- REQ-014: R_IDLE->R_START on synchronized RXD falling edge; the bit counter is cleared.
- REQ-015: R_START samples at CLKS_PER_BIT/2 (integer division); RXD high there -> glitch, back to R_IDLE, no byte, no error.
- REQ-016: R_DATA samples 8 bits, each CLKS_PER_BIT after the previous sample, shifted in LSB first.
- REQ-017: R_STOP samples CLKS_PER_BIT after bit 7; high -> byte valid one-cycle pulse; low -> framing error pulse, no byte; either -> R_IDLE.
- REQ-018: Loader states: L_SYNC, L_ADDR, L_COUNT, L_DATA.
- REQ-019: L_SYNC: bytes other than SYNC_BYTE are discarded; SYNC_BYTE -> L_ADDR, BUSY=1, ERROR cleared.
- REQ-020: L_ADDR: received byte loads the address pointer -> L_COUNT.
- REQ-021: L_COUNT: received byte loads the remaining count N; N=0 -> L_SYNC with DONE pulse; else -> L_DATA.
- REQ-022: L_DATA: each byte asserts WRITE_MEM for exactly one cycle, in the cycle after the byte-valid pulse, with ADDRESS=pointer and DATA_IN=byte.
- REQ-023: Pointer increments by 1 modulo 256 after each write (8'hFF wraps to 8'h00, no error); count decrements by 1.
- REQ-024: The write of the last byte (count 1->0) shall coincide with the DONE pulse; next cycle BUSY=0 and state L_SYNC.
- REQ-025: Writes to any address, including 8'hF0..8'hFF, are issued unfiltered; the memory decodes them.
- REQ-026: A framing error in any state other than L_SYNC sets ERROR, forces L_SYNC, BUSY=0, no DONE; already-written bytes are not undone.
- REQ-027: A framing error in L_SYNC sets ERROR only.
- REQ-028: ERROR stays high until the next accepted SYNC_BYTE or reset.
- REQ-029: ADDRESS and DATA_IN hold their last values when WRITE_MEM=0.
- REQ-030: Total latency: stop-bit sample of a data byte -> WRITE_MEM high in the next cycle; plus 2 cycles from the RXD pin for the synchronizer.

Reset
- REQ-031: RESET high shall immediately force R_IDLE, L_SYNC, WRITE_MEM=0, ADDRESS=8'h00, DATA_IN=8'h00, BUSY=0, DONE=0, ERROR=0, synchronizer flops=1, and clear all counters.
- REQ-032: RESET mid-frame shall abandon the frame with no further writes; after release the block waits for a fresh SYNC_BYTE.

Verification (CLKS_PER_BIT=4)
- REQ-033: Bytes A5,10,03,11,22,33 -> exactly 3 WRITE_MEM pulses: (10,11),(11,22),(12,33); DONE with the third pulse; BUSY low the next cycle.
- REQ-034: Bytes 00,7F,A5,FE,03,01,02,03 -> first two bytes ignored; writes (FE,01),(FF,02),(00,03).
- REQ-035: Bytes A5,40,00 -> no writes; DONE pulses one cycle after the count byte's stop sample.
- REQ-036: A5,20,02,AA then a byte with stop bit 0 -> one write (20,AA); ERROR=1, BUSY=0, no DONE; then A5,20,00 -> ERROR=0, DONE.
- REQ-037: 1-cycle low glitch on idle RXD -> no byte, no error; RESET asserted during the data byte of a frame -> all outputs at reset values at once, no write.

Source files
------------

// File: rtl/mem_loader.sv
// -----------------------------------------------------------------------------
// mem_loader
//   Receives 8N1 serial bytes on RXD and turns framed byte streams into memory
//   writes. A frame is: SYNC_BYTE, start address, byte count N, then N data
//   bytes. Each data byte becomes one WRITE_MEM strobe at an auto-incrementing
//   8-bit address.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per serial bit (4..65535)
//   SYNC_BYTE    : frame-start marker
//
// Ports
//   CLK       in   system clock, rising edge
//   RESET     in   asynchronous active-high reset
//   RXD       in   serial input, idle high, LSB first
//   WRITE_MEM out  one-cycle write strobe per data byte
//   ADDRESS   out  write address (holds when WRITE_MEM=0)
//   DATA_IN   out  write data (holds when WRITE_MEM=0)
//   BUSY      out  high from accepted sync byte until frame end or abort
//   DONE      out  one-cycle pulse when a frame completes
//   ERROR     out  sticky framing-error flag, cleared by the next sync byte
// -----------------------------------------------------------------------------
module mem_loader #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       RXD,
  output logic       WRITE_MEM,
  output logic [7:0] ADDRESS,
  output logic [7:0] DATA_IN,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERROR
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'((CLKS_PER_BIT / 2) - 1);

  // ---------------------------------------------------------------------------
  // Input synchronizer; rxd_prev is one more stage used only for edge detect.
  // ---------------------------------------------------------------------------
  logic rxd_meta_reg, rxd_sync_reg, rxd_prev_reg;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rxd_meta_reg <= 1'b1;
      rxd_sync_reg <= 1'b1;
      rxd_prev_reg <= 1'b1;
    end else begin
      rxd_meta_reg <= RXD;
      rxd_sync_reg <= rxd_meta_reg;
      rxd_prev_reg <= rxd_sync_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // Serial receiver
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} r_state_t;

  r_state_t    r_state_reg, r_state_next;
  logic [15:0] clk_cnt_reg, clk_cnt_next;
  logic [2:0]  bit_cnt_reg, bit_cnt_next;
  logic [7:0]  shift_reg, shift_next;
  logic        byte_valid;   // same cycle as a good stop-bit sample
  logic        frame_err;    // same cycle as a bad stop-bit sample

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state_reg <= R_IDLE;
      clk_cnt_reg <= 16'd0;
      bit_cnt_reg <= 3'd0;
      shift_reg   <= 8'd0;
    end else begin
      r_state_reg <= r_state_next;
      clk_cnt_reg <= clk_cnt_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
    end
  end

  always_comb begin
    r_state_next = r_state_reg;
    clk_cnt_next = clk_cnt_reg + 16'd1;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    byte_valid   = 1'b0;
    frame_err    = 1'b0;
    case (r_state_reg)
      R_IDLE: begin
        clk_cnt_next = 16'd0;
        if (!rxd_sync_reg && rxd_prev_reg) begin
          r_state_next = R_START;
          bit_cnt_next = 3'd0;
        end
      end
      R_START: begin
        // Mid-start-bit check: a line that is high again was only a glitch.
        if (clk_cnt_reg == HALF_LAST) begin
          clk_cnt_next = 16'd0;
          r_state_next = rxd_sync_reg ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (clk_cnt_reg == BIT_LAST) begin
          clk_cnt_next = 16'd0;
          shift_next   = {rxd_sync_reg, shift_reg[7:1]};
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
            r_state_next = R_STOP;
          end
        end
      end
      R_STOP: begin
        if (clk_cnt_reg == BIT_LAST) begin
          clk_cnt_next = 16'd0;
          r_state_next = R_IDLE;
          if (rxd_sync_reg) begin
            byte_valid = 1'b1;
          end else begin
            frame_err = 1'b1;
          end
        end
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Frame loader
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {L_SYNC, L_ADDR, L_COUNT, L_DATA} l_state_t;

  l_state_t   l_state_reg, l_state_next;
  logic [7:0] ptr_reg, ptr_next;
  logic [7:0] remain_reg, remain_next;
  logic       write_reg, write_next;
  logic [7:0] address_reg, address_next;
  logic [7:0] data_reg, data_next;
  logic       busy_reg, busy_next;
  logic       done_reg, done_next;
  logic       error_reg, error_next;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      l_state_reg <= L_SYNC;
      ptr_reg     <= 8'd0;
      remain_reg  <= 8'd0;
      write_reg   <= 1'b0;
      address_reg <= 8'd0;
      data_reg    <= 8'd0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      error_reg   <= 1'b0;
    end else begin
      l_state_reg <= l_state_next;
      ptr_reg     <= ptr_next;
      remain_reg  <= remain_next;
      write_reg   <= write_next;
      address_reg <= address_next;
      data_reg    <= data_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      error_reg   <= error_next;
    end
  end

  always_comb begin
    l_state_next = l_state_reg;
    ptr_next     = ptr_reg;
    remain_next  = remain_reg;
    write_next   = 1'b0;
    address_next = address_reg;
    data_next    = data_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    error_next   = error_reg;

    // BUSY stays up through the DONE cycle and drops right after it.
    if (done_reg) begin
      busy_next = 1'b0;
    end

    if (frame_err) begin
      error_next = 1'b1;
      if (l_state_reg != L_SYNC) begin
        l_state_next = L_SYNC;
        busy_next    = 1'b0;
      end
    end else if (byte_valid) begin
      case (l_state_reg)
        L_SYNC: begin
          if (shift_reg == SYNC_BYTE) begin
            l_state_next = L_ADDR;
            busy_next    = 1'b1;
            error_next   = 1'b0;
          end
        end
        L_ADDR: begin
          ptr_next     = shift_reg;
          l_state_next = L_COUNT;
        end
        L_COUNT: begin
          remain_next = shift_reg;
          if (shift_reg == 8'd0) begin
            l_state_next = L_SYNC;
            done_next    = 1'b1;
          end else begin
            l_state_next = L_DATA;
          end
        end
        L_DATA: begin
          write_next   = 1'b1;
          address_next = ptr_reg;
          data_next    = shift_reg;
          ptr_next     = ptr_reg + 8'd1;  // wraps FF -> 00
          remain_next  = remain_reg - 8'd1;
          if (remain_reg == 8'd1) begin
            l_state_next = L_SYNC;
            done_next    = 1'b1;
          end
        end
        default: l_state_next = L_SYNC;
      endcase
    end
  end

  assign WRITE_MEM = write_reg;
  assign ADDRESS   = address_reg;
  assign DATA_IN   = data_reg;
  assign BUSY      = busy_reg;
  assign DONE      = done_reg;
  assign ERROR     = error_reg;

endmodule

// File: tb/tb_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_mem_loader
//   Drives serial frames into mem_loader (CLKS_PER_BIT=4). Expected memory
//   writes are computed per frame (address + index, modulo 256) and queued; a
//   monitor pops and compares whenever WRITE_MEM or DONE is seen.
// -----------------------------------------------------------------------------
module tb_mem_loader;

  localparam int CPB = 4;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       RXD = 1'b1;
  logic       WRITE_MEM;
  logic [7:0] ADDRESS;
  logic [7:0] DATA_IN;
  logic       BUSY;
  logic       DONE;
  logic       ERROR;

  mem_loader #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
    .CLK(CLK), .RESET(RESET), .RXD(RXD),
    .WRITE_MEM(WRITE_MEM), .ADDRESS(ADDRESS), .DATA_IN(DATA_IN),
    .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
    logic       done;
  } ev_t;

  ev_t        exp_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic       exp_err = 1'b0;
  logic [7:0] fd [16];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // ---------------- monitor ----------------
  logic busy_chk = 1'b0;
  always @(negedge CLK) begin
    if (RESET) begin
      busy_chk = 1'b0;
    end else begin
      if (busy_chk) begin
        check("busy_after_done", {31'd0, BUSY}, 32'd0);
        busy_chk = 1'b0;
      end
      if (WRITE_MEM || DONE) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", {30'd0, WRITE_MEM, DONE}, 32'd0);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          if (e.wr) begin
            check("write", {14'd0, WRITE_MEM, ADDRESS, DATA_IN, DONE}, {14'd0, e});
            if (!e.done) check("busy_in_write", {31'd0, BUSY}, 32'd1);
          end else begin
            check("done_only", {30'd0, WRITE_MEM, DONE}, 32'd1);
          end
          $display("event: wr=%0b addr=%02h data=%02h done=%0b", WRITE_MEM, ADDRESS, DATA_IN, DONE);
          if (DONE) busy_chk = 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    @(negedge CLK);
    RXD = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      RXD = b[i];
      repeat (CPB) @(negedge CLK);
    end
    RXD = stop_ok;
    repeat (CPB) @(negedge CLK);
    RXD = 1'b1;
    repeat (2 * CPB) @(negedge CLK);
    check("queue_drained", exp_q.size(), 32'd0);
    exp_q.delete();
    $display("byte %02h stop_ok=%0b sent", b, stop_ok);
  endtask

  task automatic push_ev(input logic wr, input logic [7:0] a, input logic [7:0] d, input logic dn);
    ev_t e;
    e.wr = wr; e.addr = a; e.data = d; e.done = dn;
    exp_q.push_back(e);
  endtask

  // Frame: sync, address, count n, data fd[0..n-1]; abort_at >= 0 replaces
  // that data byte with one carrying a bad stop bit.
  task automatic send_frame(input logic [7:0] a, input int n, input int abort_at);
    send_byte(8'hA5, 1'b1);
    exp_err = 1'b0;
    check("busy_after_sync", {31'd0, BUSY}, 32'd1);
    check("error_after_sync", {31'd0, ERROR}, 32'd0);
    send_byte(a, 1'b1);
    if (n == 0) push_ev(1'b0, 8'h00, 8'h00, 1'b1);
    send_byte(8'(n), 1'b1);
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) begin
        send_byte(8'($urandom_range(0, 255)), 1'b0);
        exp_err = 1'b1;
        break;
      end
      push_ev(1'b1, 8'(a + 8'(i)), fd[i], (i == n - 1));
      send_byte(fd[i], 1'b1);
    end
    check("busy_frame_end", {31'd0, BUSY}, 32'd0);
    check("error_frame_end", {31'd0, ERROR}, {31'd0, exp_err});
  endtask

  task automatic send_garbage(input logic [7:0] b);
    send_byte(b, 1'b1);
    check("busy_garbage", {31'd0, BUSY}, 32'd0);
    check("error_garbage", {31'd0, ERROR}, {31'd0, exp_err});
  endtask

  task automatic check_reset_outputs(input string nm);
    check(nm, {13'd0, WRITE_MEM, ADDRESS, DATA_IN, BUSY, DONE, ERROR}, 32'd0);
  endtask

  initial begin
    // reset values
    repeat (3) @(negedge CLK);
    check_reset_outputs("reset_values");
    RESET = 1'b0;
    repeat (4) @(negedge CLK);
    check_reset_outputs("after_release");

    // three-byte frame
    fd[0] = 8'h11; fd[1] = 8'h22; fd[2] = 8'h33;
    send_frame(8'h10, 3, -1);

    // leading noise then a frame wrapping past FF
    send_garbage(8'h00);
    send_garbage(8'h7F);
    fd[0] = 8'h01; fd[1] = 8'h02; fd[2] = 8'h03;
    send_frame(8'hFE, 3, -1);

    // empty frame
    send_frame(8'h40, 0, -1);

    // abort on second data byte, then recovery
    fd[0] = 8'hAA; fd[1] = 8'hBB;
    send_frame(8'h20, 2, 1);
    send_frame(8'h20, 0, -1);

    // framing error while waiting for sync only sets ERROR
    send_byte(8'h5A, 1'b0);
    exp_err = 1'b1;
    check("error_in_sync", {31'd0, ERROR}, 32'd1);
    check("busy_in_sync", {31'd0, BUSY}, 32'd0);
    send_frame(8'h08, 1, -1);

    // one-cycle glitch on idle line
    @(negedge CLK); RXD = 1'b0;
    @(negedge CLK); RXD = 1'b1;
    repeat (3 * CPB) @(negedge CLK);
    check("glitch_no_event", exp_q.size(), 32'd0);
    check("glitch_error", {31'd0, ERROR}, 32'd0);
    fd[0] = 8'h77;
    send_frame(8'h30, 1, -1);

    // reset in the middle of a data byte
    send_byte(8'hA5, 1'b1);
    send_byte(8'h50, 1'b1);
    send_byte(8'h03, 1'b1);
    check("busy_before_reset", {31'd0, BUSY}, 32'd1);
    @(negedge CLK); RXD = 1'b0;
    repeat (3 * CPB) @(negedge CLK);
    RXD = 1'b1;
    @(posedge CLK);
    #2 RESET = 1'b1;
    #1 check_reset_outputs("async_reset_midframe");
    repeat (3) @(negedge CLK);
    RXD = 1'b1;
    RESET = 1'b0;
    exp_err = 1'b0;
    exp_q.delete();
    repeat (12 * CPB) @(negedge CLK);
    check_reset_outputs("after_midframe_reset");
    // data-looking bytes without a sync must be ignored
    send_garbage(8'h11);
    send_garbage(8'h22);
    fd[0] = 8'h9C; fd[1] = 8'h3D;
    send_frame(8'h60, 2, -1);

    // randomized frames
    for (int it = 0; it < 30; it++) begin
      logic [7:0] a;
      int n, ab;
      int ng;
      ng = $urandom_range(0, 2);
      for (int g = 0; g < ng; g++) begin
        logic [7:0] gb;
        gb = 8'($urandom_range(0, 255));
        if (gb == 8'hA5) gb = 8'h5A;
        send_garbage(gb);
      end
      if ($urandom_range(0, 5) == 0) begin
        send_byte(8'($urandom_range(0, 255)), 1'b0);
        exp_err = 1'b1;
        check("rand_error_in_sync", {31'd0, ERROR}, 32'd1);
      end
      if ($urandom_range(0, 2) == 0) a = 8'hF8 + 8'($urandom_range(0, 7));
      else                           a = 8'($urandom_range(0, 255));
      n = $urandom_range(0, 6);
      for (int i = 0; i < n; i++) fd[i] = 8'($urandom_range(0, 255));
      ab = -1;
      if (n > 0 && $urandom_range(0, 4) == 0) ab = $urandom_range(0, n - 1);
      send_frame(a, n, ab);
    end

    repeat (4) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
